// File: rtl/sumador_pkg.sv
// Shared types for the multi-cycle adder/subtractor.
// FSM states, operation codes and idx counter sizing.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sum_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sumador_nbit.sv
// Combinational N-bit ripple-carry slice.
// Also exposes the carry into the MSB for signed overflow.
module sumador_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] c;

    // Ripple the carry bit by bit through the slice
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/sumador_multiciclo.sv
// Multi-cycle adder/subtractor, CHUNK bits per cycle.
// Optional signed-overflow output enabled by SUMADOR_OVF_EN.
module sumador_multiciclo
    import sumador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] zi,
    output logic             co
`ifdef SUMADOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = idx_width(NCH);
    localparam logic [IW-1:0] LAST    = IW'(NCH - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("sumador_multiciclo: WIDTH must be a multiple of CHUNK");
    end

    sum_state_t state_q;
    sum_state_t state_d;

    logic [NCH-1:0][CHUNK-1:0] a_q;
    logic [NCH-1:0][CHUNK-1:0] b_q;
    logic [NCH-1:0][CHUNK-1:0] zi_q;
    logic                      carry_q;
    logic [IW-1:0]             idx_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] sl_s;
    logic             sl_co;
    logic             sl_cmsb;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign last     = (idx_q == LAST);
    assign zi       = zi_q;

    sumador_nbit #(
        .N (CHUNK)
    ) u_slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .ci    (carry_q),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb (sl_cmsb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; illegal encodings fall back to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept    ? RUN  : IDLE;
            RUN:     state_d = last      ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            zi_q      <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= xi;
                        b_q     <= (op == OP_SUB) ? ~yi : yi;
                        carry_q <= op;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    zi_q[idx_q] <= sl_s;
                    carry_q     <= sl_co;
                    idx_q       <= idx_q + IDX_ONE;
                    if (last) begin
                        idx_q     <= '0;
                        co        <= sl_co;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SUMADOR_OVF_EN
    // Signed overflow from the carries around the top bit of the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state_q == RUN) && last) begin
            ovf <= sl_cmsb ^ sl_co;
        end
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = sl_cmsb;
`endif

endmodule

// File: tb/tb_sumador_multiciclo.sv
// Self-checking bench for sumador_multiciclo (16/4 and 8/8).
// Covers SUMADOR_OVF_EN when the macro is defined.
module tb_sumador_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] xi;
    logic [15:0] yi;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] zi;
    logic        co;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  xi8;
    logic [7:0]  yi8;
    logic        op8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  zi8;
    logic        co8;

`ifdef SUMADOR_OVF_EN
    logic        ovf;
    logic        ovf8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] sb[$];

    always #5 clk = ~clk;

    sumador_multiciclo #(
        .WIDTH (16),
        .CHUNK (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xi        (xi),
        .yi        (yi),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zi        (zi),
        .co        (co)
`ifdef SUMADOR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    sumador_multiciclo #(
        .WIDTH (8),
        .CHUNK (8)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .xi        (xi8),
        .yi        (yi8),
        .op        (op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .zi        (zi8),
        .co        (co8)
`ifdef SUMADOR_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic        o);
        logic [16:0] r;
        logic        v;
        if (o) r = {(x >= y), 16'(x - y)};
        else   r = {1'b0, x} + {1'b0, y};
        if (o) v = (x[15] != y[15]) && (r[15] != x[15]);
        else   v = (x[15] == y[15]) && (r[15] != x[15]);
        return {v, r};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x,
                        input logic [15:0] y,
                        input logic        o);
        int n = 0;
        xi       = x;
        yi       = y;
        op       = o;
        in_valid = 1'b1;
        sb.push_back(model(x, y, o));
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit noise, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            if (noise) begin
                in_valid = 1'b1;
                xi       = 16'($urandom);
                yi       = 16'($urandom);
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("out_wait", 32'(out_valid), 32'd1);
        if (exp_lat > 0) chk("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic take(input int hold, input bit noise, input string tag);
        logic [17:0] e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                xi       = 16'($urandom);
            end
            step();
            chk({tag, "_hold"}, {14'd0, out_valid, co, zi}, {14'd0, 1'b1, e[16:0]});
        end
        in_valid = 1'b0;
        chk(tag, {14'd0, out_valid, co, zi}, {14'd0, 1'b1, e[16:0]});
`ifdef SUMADOR_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(e[17]));
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        logic        ro;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        xi         = '0;
        yi         = '0;
        op         = 1'b0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        xi8        = '0;
        yi8        = '0;
        op8        = 1'b0;
        out_ready8 = 1'b0;
        #22;
        chk("rst_state", {28'd0, in_ready, out_valid, co, 1'b0}, 32'b1000);
        chk("rst_zi", 32'(zi), 32'd0);
        rst_n = 1'b1;
        step();

        send(16'h1234, 16'h0F0F, 1'b0);
        wait_out(1'b0, 4);
        take(0, 1'b0, "add_basic");

        send(16'hFFFF, 16'h0001, 1'b0);
        wait_out(1'b0, 4);
        take(0, 1'b0, "add_carry");

        send(16'h0005, 16'h0007, 1'b1);
        wait_out(1'b0, 4);
        take(0, 1'b0, "sub_borrow");

        send(16'h0007, 16'h0005, 1'b1);
        wait_out(1'b0, 4);
        take(0, 1'b0, "sub_pos");

        send(16'hA5A5, 16'h5A5B, 1'b0);
        wait_out(1'b1, 4);
        take(3, 1'b1, "backpress");

        send(16'h1111, 16'h2222, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_zi", 32'(zi), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        #4;
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        send(16'h0001, 16'h0001, 1'b0);
        wait_out(1'b0, 4);
        take(0, 1'b0, "post_rst");

`ifdef SUMADOR_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_out(1'b0, 4);
        take(1, 1'b0, "ovf_add");
        send(16'h8000, 16'h0001, 1'b1);
        wait_out(1'b0, 4);
        take(0, 1'b0, "ovf_sub");
        send(16'h0001, 16'h0001, 1'b0);
        wait_out(1'b0, 4);
        take(0, 1'b0, "ovf_none");
`endif

        xi8       = 8'hFF;
        yi8       = 8'h01;
        op8       = 1'b0;
        in_valid8 = 1'b1;
        chk("n1_ready", 32'(in_ready8), 32'd1);
        step();
        in_valid8 = 1'b0;
        chk("n1_busy", {30'd0, in_ready8, out_valid8}, 32'b00);
        step();
        chk("n1_result", {23'd0, out_valid8, co8, zi8}, {23'd0, 1'b1, 1'b1, 8'h00});
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        chk("n1_drop", 32'(out_valid8), 32'd0);

        xi8       = 8'h12;
        yi8       = 8'h34;
        op8       = 1'b1;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        chk("n1_sub", {23'd0, out_valid8, co8, zi8}, {23'd0, 1'b1, 1'b0, 8'hDE});
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            ro = 1'($urandom);
            if (i % 50 == 0) ry = rx;
            send(rx, ry, ro);
            wait_out(1'b0, 4);
            take($urandom_range(0, 2), 1'b0, "random");
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
